// File: rtl/i2s_tx.sv
// Standard-format I2S transmitter, 16-bit stereo, fractional bit-clock accumulator.
// Optional build macro I2S_TX_MONO_MIX_EN: latch the L/R average into both slots.
module i2s_tx #(
  parameter int unsigned CLK_HZ    = 32000000,
  parameter int unsigned SAMPLE_HZ = 48000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] audio_l,
  input  logic [15:0] audio_r,
  output logic        sample_tick,
  output logic        i2s_bclk,
  output logic        i2s_lrck,
  output logic        i2s_din
);

  localparam int unsigned TOG_HZ = 64 * SAMPLE_HZ;
  localparam int unsigned ACC_W  = $clog2(CLK_HZ);
  localparam logic [ACC_W-1:0] ACC_STEP = ACC_W'(TOG_HZ);
  localparam logic [ACC_W-1:0] ACC_WRAP = ACC_W'(CLK_HZ - TOG_HZ);

  logic [ACC_W-1:0] acc, acc_nxt;
  logic [4:0]       bit_cnt, bit_cnt_nxt;
  logic [15:0]      lat_l, lat_l_nxt;
  logic [15:0]      lat_r, lat_r_nxt;
  logic             bclk_nxt, lrck_nxt, din_nxt, tick_nxt;
  logic             tog_c;

`ifdef I2S_TX_MONO_MIX_EN
  logic [16:0] mix_sum_c;
  logic [15:0] mix_c;

  // 17-bit signed sum, arithmetic shift right by one, truncated to 16 bits
  always_comb begin
    mix_sum_c = {audio_l[15], audio_l} + {audio_r[15], audio_r};
    mix_c     = mix_sum_c[16:1];
  end
`endif

  // Next-state: accumulator strobe, bit clock toggle, serializer on falling edge
  always_comb begin
    acc_nxt     = acc + ACC_STEP;
    bclk_nxt    = i2s_bclk;
    bit_cnt_nxt = bit_cnt;
    lrck_nxt    = i2s_lrck;
    din_nxt     = i2s_din;
    tick_nxt    = 1'b0;
    lat_l_nxt   = lat_l;
    lat_r_nxt   = lat_r;
    tog_c       = (acc >= ACC_WRAP);

    if (tog_c) begin
      acc_nxt  = acc - ACC_WRAP;
      bclk_nxt = ~i2s_bclk;
      if (i2s_bclk) begin
        // old bit_cnt equals (n-1) mod 32, i.e. the slot/bit being sent
        bit_cnt_nxt = bit_cnt + 5'd1;
        lrck_nxt    = bit_cnt_nxt[4];
        din_nxt     = bit_cnt[4] ? lat_r[~bit_cnt[3:0]] : lat_l[~bit_cnt[3:0]];
        if (bit_cnt == 5'd31) begin
          tick_nxt = 1'b1;
`ifdef I2S_TX_MONO_MIX_EN
          lat_l_nxt = mix_c;
          lat_r_nxt = mix_c;
`else
          lat_l_nxt = audio_l;
          lat_r_nxt = audio_r;
`endif
        end
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      acc         <= '0;
      bit_cnt     <= 5'd31;
      lat_l       <= '0;
      lat_r       <= '0;
      i2s_bclk    <= 1'b0;
      i2s_lrck    <= 1'b0;
      i2s_din     <= 1'b0;
      sample_tick <= 1'b0;
    end else begin
      acc         <= acc_nxt;
      bit_cnt     <= bit_cnt_nxt;
      lat_l       <= lat_l_nxt;
      lat_r       <= lat_r_nxt;
      i2s_bclk    <= bclk_nxt;
      i2s_lrck    <= lrck_nxt;
      i2s_din     <= din_nxt;
      sample_tick <= tick_nxt;
    end
  end

endmodule
